dcache_data_array: RTL and testbench

- Parametrised, multi-way data store for the L1 data cache. Successor to the single-way, fixed-geometry data RAM wrapper.
- Holds WAYS independent data banks. Each bank is indexed by set and word offset.
- Provides:
  - a registered all-ways read port for hit selection;
  - a byte-enabled store write port;
  - a sequenced line-refill port that writes one word per beat under an internal counter.
- Sits between the dcache controller (tag compare, LRU, AXI refill FSM) and inferred block RAM.

---
 rtl/dcache_data_array.sv | 140 ++++++++++++++
 tb/tb_dcache_data_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_data_array.sv
// rtl/dcache_data_array.sv - multi-way L1 dcache data store with store port and sequenced line refill
// Optional write-first read bypass: define DCACHE_DATA_BYPASS_EN.
module dcache_data_array #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 7,
    parameter int OFF_BITS = 3,
    parameter int ADDR_W   = 32,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_valid,
    output logic [32*WAYS-1:0]   rd_data,
    input  logic                 wr_en,
    output logic                 wr_ready,
    input  logic [WAY_W-1:0]     wr_way,
    input  logic [3:0]           wr_wen,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 refill_start,
    input  logic [ADDR_W-1:0]    refill_addr,
    input  logic [WAY_W-1:0]     refill_way,
    input  logic                 refill_valid,
    input  logic [31:0]          refill_data,
    output logic                 refill_busy,
    output logic                 refill_done
);
    localparam int IDX_W = SET_BITS + OFF_BITS;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    logic [31:0]         mem [WAYS][DEPTH];
    state_t              state;
    logic [OFF_BITS-1:0] beat_cnt;
    logic [SET_BITS-1:0] fill_set;
    logic [WAY_W-1:0]    fill_way;

    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                beat_we;
    logic                w_en;
    logic [WAY_W-1:0]    w_way;
    logic [IDX_W-1:0]    w_idx;
    logic [3:0]          w_be;
    logic [31:0]         w_data;
    logic                unused_addr_bits;

    assign rd_idx  = rd_addr[IDX_W+1:2];
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{rd_addr, wr_addr, refill_addr};

    // The single RAM write port goes to the refill beat first; a colliding store must be retried.
    assign beat_we  = (state == FILL) && refill_valid;
    assign wr_ready = !beat_we;

    always_comb begin
        w_en   = beat_we || wr_en;
        w_way  = wr_way;
        w_idx  = wr_idx;
        w_be   = wr_wen;
        w_data = wr_data;
        if (beat_we) begin
            w_way  = fill_way;
            w_idx  = {fill_set, beat_cnt};
            w_be   = 4'hF;
            w_data = refill_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_en && (w_way == WAY_W'(w))) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        mem[w][w_idx][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    for (int b = 0; b < 4; b++) begin
`ifdef DCACHE_DATA_BYPASS_EN
                        if (w_en && (w_way == WAY_W'(w)) && (w_idx == rd_idx) && w_be[b])
                            rd_data[32*w + 8*b +: 8] <= w_data[8*b +: 8];
                        else
`endif
                            rd_data[32*w + 8*b +: 8] <= mem[w][rd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            fill_set    <= '0;
            fill_way    <= '0;
            refill_busy <= 1'b0;
            refill_done <= 1'b0;
        end else begin
            refill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (refill_start) begin
                        state       <= FILL;
                        beat_cnt    <= '0;
                        fill_set    <= refill_addr[IDX_W+1:OFF_BITS+2];
                        fill_way    <= refill_way;
                        refill_busy <= 1'b1;
                    end
                end
                FILL: begin
                    if (refill_valid) begin
                        beat_cnt <= beat_cnt + OFF_BITS'(1);
                        if (beat_cnt == {OFF_BITS{1'b1}}) begin
                            state       <= IDLE;
                            refill_busy <= 1'b0;
                            refill_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_data_array.sv
// tb/tb_dcache_data_array.sv - randomized bench for dcache_data_array against a word-level cache model
module tb_dcache_data_array;
    localparam int WAYS = 2;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        wr_en;
    logic        wr_ready;
    logic [0:0]  wr_way;
    logic [3:0]  wr_wen;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        refill_start;
    logic [31:0] refill_addr;
    logic [0:0]  refill_way;
    logic        refill_valid;
    logic [31:0] refill_data;
    logic        refill_busy;
    logic        refill_done;

    dcache_data_array dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_way(wr_way), .wr_wen(wr_wen),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .refill_start(refill_start), .refill_addr(refill_addr), .refill_way(refill_way),
        .refill_valid(refill_valid), .refill_data(refill_data),
        .refill_busy(refill_busy), .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit [31:0] mmem   [WAYS][WORDS];
    bit        mknown [WAYS][WORDS];
    bit        m_fill;
    int        m_cnt;
    int        m_line;
    int        m_way;
    bit [31:0] exp_rd    [WAYS];
    bit        exp_known [WAYS];
    bit        exp_valid;
    bit        exp_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'd1023);
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] be);
        bit [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One clock: predict from inputs at the falling edge, compare registered outputs 1ns after the rise.
    task automatic cycle();
        bit        beat, dow;
        int        wway, widx;
        bit [3:0]  wbe;
        bit [31:0] wdat;
        @(negedge clk);
        beat = m_fill && refill_valid;
        dow  = 1'b0;
        check("wr_ready", {31'b0, wr_ready}, {31'b0, !beat});
        if (rst) begin
            exp_valid = 1'b0;
            for (int w = 0; w < WAYS; w++) begin exp_rd[w] = '0; exp_known[w] = 1'b1; end
        end else begin
            exp_valid = rd_en;
            if (rd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    exp_rd[w]    = mmem[w][word_idx(rd_addr)];
                    exp_known[w] = mknown[w][word_idx(rd_addr)];
                end
            end
        end
        if (beat) begin
            dow = 1'b1; wway = m_way; widx = m_line * 8 + m_cnt; wbe = 4'hF; wdat = refill_data;
        end else if (wr_en) begin
            dow = 1'b1; wway = int'(wr_way); widx = word_idx(wr_addr); wbe = wr_wen; wdat = wr_data;
        end
        if (dow) begin
`ifdef DCACHE_DATA_BYPASS_EN
            if (!rst && rd_en && widx == word_idx(rd_addr)) begin
                exp_rd[wway]    = merge(exp_rd[wway], wdat, wbe);
                exp_known[wway] = exp_known[wway] || (wbe == 4'hF);
            end
`endif
            mmem[wway][widx]   = merge(mmem[wway][widx], wdat, wbe);
            mknown[wway][widx] = mknown[wway][widx] || (wbe == 4'hF);
        end
        exp_done = 1'b0;
        if (rst) begin
            m_fill = 1'b0; m_cnt = 0;
        end else if (!m_fill && refill_start) begin
            m_fill = 1'b1; m_cnt = 0;
            m_line = int'((refill_addr >> 5) & 32'd127);
            m_way  = int'(refill_way);
        end else if (beat) begin
            m_cnt++;
            if (m_cnt == 8) begin m_fill = 1'b0; m_cnt = 0; exp_done = 1'b1; end
        end
        @(posedge clk);
        #1;
        check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_valid});
        for (int w = 0; w < WAYS; w++)
            if (exp_known[w]) check($sformatf("rd_data_w%0d", w), rd_data[32*w +: 32], exp_rd[w]);
        check("refill_busy", {31'b0, refill_busy}, {31'b0, m_fill});
        check("refill_done", {31'b0, refill_done}, {31'b0, exp_done});
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; refill_start = 1'b0; refill_valid = 1'b0;
        wr_wen = 4'h0;
    endtask

    task automatic read_word(input logic [31:0] a);
        rd_en = 1'b1; rd_addr = a;
        cycle();
        rd_en = 1'b0;
    endtask

    int        dn;
    int        i;
    bit        bub;
    bit [31:0] exp5;

    initial begin
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_way = '0;
        refill_addr = '0; refill_way = '0; refill_data = '0;
        m_fill = 1'b0; m_cnt = 0; m_line = 0; m_way = 0;
        idle_inputs();

        // 1: reset and first read latency
        rst = 1'b1; rd_en = 1'b1; rd_addr = 32'h0000_0040;
        cycle(); cycle();
        check("t1_rd_valid_rst", {31'b0, rd_valid}, 32'd0);
        check("t1_rd_data_rst", rd_data[31:0], 32'd0);
        rst = 1'b0;
        cycle();
        check("t1_rd_valid", {31'b0, rd_valid}, 32'd1);
        rd_en = 1'b0;
        cycle();

        // 2: refill way 1 with a bubble
        refill_start = 1'b1; refill_addr = 32'h0000_1020; refill_way = 1'b1;
        cycle();
        refill_start = 1'b0;
        check("t2_busy_start", {31'b0, refill_busy}, 32'd1);
        dn = 0; i = 0; bub = 1'b0;
        while (i < 8) begin
            if (i == 3 && !bub) begin refill_valid = 1'b0; bub = 1'b1; end
            else begin refill_valid = 1'b1; refill_data = 32'h1111_0000 + i; i++; end
            cycle();
            if (refill_done) dn++;
            if (i < 8) check("t2_busy", {31'b0, refill_busy}, 32'd1);
        end
        refill_valid = 1'b0;
        cycle(); if (refill_done) dn++;
        cycle(); if (refill_done) dn++;
        check("t2_done_pulses", dn, 1);
        check("t2_busy_end", {31'b0, refill_busy}, 32'd0);
        read_word(32'h0000_1034);
        check("t2_read", rd_data[63:32], 32'h1111_0005);

        // 3: byte-enabled store
        wr_en = 1'b1; wr_way = 1'b1; wr_addr = 32'h0000_1034; wr_wen = 4'b0011; wr_data = 32'hAABB_CCDD;
        cycle();
        wr_en = 1'b0;
        read_word(32'h0000_1034);
        check("t3_read", rd_data[63:32], 32'h1111_CCDD);

        // 4: store colliding with a refill beat is rejected then retried
        refill_start = 1'b1; refill_addr = 32'h0000_1020; refill_way = 1'b0;
        cycle();
        refill_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            refill_valid = 1'b1; refill_data = 32'h2222_0000 + k;
            if (k == 2) begin
                wr_en = 1'b1; wr_way = 1'b1; wr_addr = 32'h0000_1030; wr_wen = 4'hF; wr_data = 32'h1234_5678;
                #1 check("t4_wr_ready_low", {31'b0, wr_ready}, 32'd0);
                cycle();
                refill_valid = 1'b0;
                #1 check("t4_wr_ready_high", {31'b0, wr_ready}, 32'd1);
                cycle();
                wr_en = 1'b0;
            end else begin
                cycle();
            end
        end
        refill_valid = 1'b0;
        cycle();
        read_word(32'h0000_1028);
        check("t4_refill_word", rd_data[31:0], 32'h2222_0002);
        read_word(32'h0000_1030);
        check("t4_store_word", rd_data[63:32], 32'h1234_5678);
        check("t4_refill_word4", rd_data[31:0], 32'h2222_0004);

        // 5: read and store to the same word on one edge
`ifdef DCACHE_DATA_BYPASS_EN
        exp5 = 32'h5566_CCDD;
`else
        exp5 = 32'h1111_CCDD;
`endif
        rd_en = 1'b1; rd_addr = 32'h0000_1034;
        wr_en = 1'b1; wr_way = 1'b1; wr_addr = 32'h0000_1034; wr_wen = 4'b1100; wr_data = 32'h5566_7788;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        check("t5_same_edge", rd_data[63:32], exp5);
        read_word(32'h0000_1034);
        check("t5_after", rd_data[63:32], 32'h5566_CCDD);

        // 6: reset mid-refill, then a clean refill
        refill_start = 1'b1; refill_addr = 32'h0000_2000; refill_way = 1'b1;
        cycle();
        refill_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            refill_valid = 1'b1; refill_data = 32'h3333_0000 + k;
            cycle();
        end
        refill_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_busy_after_rst", {31'b0, refill_busy}, 32'd0);
        check("t6_no_done", {31'b0, refill_done}, 32'd0);
        refill_start = 1'b1;
        cycle();
        refill_start = 1'b0; dn = 0;
        for (int k = 0; k < 8; k++) begin
            refill_valid = 1'b1; refill_data = 32'h4444_0000 + k;
            cycle();
            if (refill_done) dn++;
        end
        refill_valid = 1'b0;
        cycle(); if (refill_done) dn++;
        check("t6_done_pulses", dn, 1);
        read_word(32'h0000_2000);
        check("t6_word0", rd_data[63:32], 32'h4444_0000);
        read_word(32'h0000_201C);
        check("t6_word7", rd_data[63:32], 32'h4444_0007);

        // random traffic concentrated on four lines to force collisions
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            rd_en        = $urandom_range(0, 1);
            rd_addr      = {$urandom_range(0, 15), 12'h000} | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            wr_en        = ($urandom_range(0, 9) < 4);
            wr_way       = 1'($urandom_range(0, 1));
            wr_wen       = 4'($urandom_range(0, 15));
            wr_addr      = {$urandom_range(0, 15), 12'h000} | ($urandom_range(0, 31) << 2);
            wr_data      = $urandom;
            refill_start = ($urandom_range(0, 19) == 0);
            refill_addr  = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            refill_way   = 1'($urandom_range(0, 1));
            refill_valid = ($urandom_range(0, 9) < 6);
            refill_data  = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
